// File: rtl/cpu_sequencer_if.sv
// Memory request/acknowledge port between the LiteCPU sequencer (master) and the bus (slave).
interface cpu_sequencer_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
) ();
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/load/calc/store sequencer for the LiteCPU core with a bus-timeout fault trap.
module cpu_sequencer #(
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       MAX_WAIT = 15,
  parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  cpu_sequencer_if.master   mem,
  input  logic              dec_load,
  input  logic              dec_store,
  input  logic [ADDR_W-1:0] dec_addr,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_target,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] operand,
  output logic [ADDR_W-1:0] pc,
  output logic              calc_en,
  output logic [3:0]        state,
  output logic              fault
);

  localparam int unsigned      WaitW   = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [WaitW-1:0] MaxWait = WaitW'(MAX_WAIT);

  typedef enum logic [3:0] {
    StFetchBegin = 4'd0,
    StFetchIo    = 4'd1,
    StFetchEnd   = 4'd2,
    StExecBegin  = 4'd3,
    StLoadBegin  = 4'd4,
    StLoadIo     = 4'd5,
    StLoadEnd    = 4'd6,
    StCalc       = 4'd7,
    StStoreBegin = 4'd8,
    StStoreIo    = 4'd9,
    StFault      = 4'd10
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, addr_q, addr_d, ea_q, ea_d;
  logic [DATA_W-1:0] ir_q, ir_d, operand_q, operand_d, wdata_q, wdata_d;
  logic              store_q, store_d;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic              timeout;

  assign timeout = (MAX_WAIT != 0) && (wait_q == MaxWait);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StFetchBegin;
      pc_q      <= PC_RESET;
      addr_q    <= '0;
      ea_q      <= '0;
      ir_q      <= '0;
      operand_q <= '0;
      wdata_q   <= '0;
      store_q   <= 1'b0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      ea_q      <= ea_d;
      ir_q      <= ir_d;
      operand_q <= operand_d;
      wdata_q   <= wdata_d;
      store_q   <= store_d;
      wait_q    <= wait_d;
    end
  end

  // wait_d defaults to zero so the counter is clear on every entry into an IO state.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    ea_d      = ea_q;
    ir_d      = ir_q;
    operand_d = operand_q;
    wdata_d   = wdata_q;
    store_d   = store_q;
    wait_d    = '0;
    case (state_q)
      StFetchBegin: begin
        if (run) begin
          addr_d  = pc_q;
          state_d = StFetchIo;
        end
      end
      StFetchIo: begin
        if (mem.mem_ack) begin
          ir_d    = mem.mem_rdata;
          state_d = StFetchEnd;
        end else if (timeout) begin
          state_d = StFault;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StFetchEnd: begin
        pc_d    = pc_q + ADDR_W'(1);
        state_d = StExecBegin;
      end
      StExecBegin: begin
        ea_d    = dec_addr;
        store_d = dec_store;
        state_d = dec_load ? StLoadBegin : StCalc;
      end
      StLoadBegin: begin
        addr_d  = ea_q;
        state_d = StLoadIo;
      end
      StLoadIo: begin
        if (mem.mem_ack) begin
          operand_d = mem.mem_rdata;
          state_d   = StLoadEnd;
        end else if (timeout) begin
          state_d = StFault;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StLoadEnd: state_d = StCalc;
      StCalc: begin
        wdata_d = alu_result;
        if (pc_load) pc_d = pc_target;
        state_d = store_q ? StStoreBegin : StFetchBegin;
      end
      StStoreBegin: begin
        addr_d  = ea_q;
        state_d = StStoreIo;
      end
      StStoreIo: begin
        if (mem.mem_ack) begin
          state_d = StFetchBegin;
        end else if (timeout) begin
          state_d = StFault;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StFault: state_d = StFault;
      default: state_d = StFault;
    endcase
  end

  always_comb begin
    mem.mem_req = 1'b0;
    mem.mem_we  = 1'b0;
    calc_en     = 1'b0;
    fault       = 1'b0;
    case (state_q)
      StFetchIo, StLoadIo: mem.mem_req = 1'b1;
      StStoreIo: begin
        mem.mem_req = 1'b1;
        mem.mem_we  = 1'b1;
      end
      StCalc:  calc_en = 1'b1;
      StFault: fault   = 1'b1;
      default: ;
    endcase
  end

  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign ir            = ir_q;
  assign operand       = operand_q;
  assign pc            = pc_q;
  assign state         = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: one DUT with MAX_WAIT=4, one with the timeout disabled.
module tb_cpu_sequencer;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0, run = 1'b0, rst_n2 = 1'b0, run2 = 1'b0;
  logic          dec_load = 1'b0, dec_store = 1'b0, pc_load = 1'b0;
  logic [AW-1:0] dec_addr = '0, pc_target = '0;
  logic [DW-1:0] alu_result = '0;
  logic [DW-1:0] ir, operand, ir2, operand2;
  logic [AW-1:0] pc, pc2;
  logic          calc_en, fault, calc_en2, fault2;
  logic [3:0]    state, state2;
  int            n_vec = 0;
  int            n_err = 0;

  cpu_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  cpu_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus2 ();

  cpu_sequencer #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(4), .PC_RESET(16'h0100)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .mem(bus),
    .dec_load(dec_load), .dec_store(dec_store), .dec_addr(dec_addr),
    .alu_result(alu_result), .pc_load(pc_load), .pc_target(pc_target),
    .ir(ir), .operand(operand), .pc(pc), .calc_en(calc_en), .state(state), .fault(fault)
  );

  cpu_sequencer #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(0), .PC_RESET(16'h0000)) dut_nt (
    .clk(clk), .rst_n(rst_n2), .run(run2), .mem(bus2),
    .dec_load(dec_load), .dec_store(dec_store), .dec_addr(dec_addr),
    .alu_result(alu_result), .pc_load(pc_load), .pc_target(pc_target),
    .ir(ir2), .operand(operand2), .pc(pc2), .calc_en(calc_en2), .state(state2),
    .fault(fault2)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    bus2.mem_ack = 1'b0; bus2.mem_rdata = '0;
    step(); step();
    n_vec++; if (state !== 4'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", state); end
    n_vec++; if (pc !== 16'h0100) begin n_err++; $display("FAIL reset_pc: got %h want 0100", pc); end
    n_vec++; if (ir !== 16'h0) begin n_err++; $display("FAIL reset_ir: got %h want 0", ir); end
    n_vec++; if (operand !== 16'h0) begin n_err++; $display("FAIL reset_operand: got %h", operand); end
    n_vec++; if (bus.mem_addr !== 16'h0) begin n_err++; $display("FAIL reset_addr: got %h", bus.mem_addr); end
    n_vec++; if (bus.mem_wdata !== 16'h0) begin n_err++; $display("FAIL reset_wdata: got %h", bus.mem_wdata); end
    n_vec++;
    if ({bus.mem_req, bus.mem_we, calc_en, fault} !== 4'b0000) begin
      n_err++; $display("FAIL reset_flags: got %b want 0000", {bus.mem_req, bus.mem_we, calc_en, fault});
    end
  endtask

  task automatic test_plain();
    logic [3:0] exp_st [5];
    exp_st = '{4'd1, 4'd2, 4'd3, 4'd7, 4'd0};
    rst_n = 1'b1; run = 1'b1; bus.mem_ack = 1'b1; dec_load = 1'b0; dec_store = 1'b0; pc_load = 1'b0;
    for (int k = 0; k < 3; k++) begin
      for (int p = 0; p < 5; p++) begin
        bus.mem_rdata = DW'(16'hA000 + k);
        step();
        n_vec++;
        if (state !== exp_st[p]) begin
          n_err++; $display("FAIL plain_state k=%0d p=%0d: got %0d want %0d", k, p, state, exp_st[p]);
        end
        n_vec++;
        if (calc_en !== (p == 3)) begin
          n_err++; $display("FAIL plain_calc_en k=%0d p=%0d: got %b", k, p, calc_en);
        end
        n_vec++;
        if (bus.mem_we !== 1'b0) begin n_err++; $display("FAIL plain_we k=%0d p=%0d: got 1 want 0", k, p); end
        if (p == 0) begin
          n_vec++;
          if (bus.mem_addr !== AW'(16'h0100 + k) || bus.mem_req !== 1'b1) begin
            n_err++; $display("FAIL plain_fetch_addr k=%0d: got %h req %b", k, bus.mem_addr, bus.mem_req);
          end
        end
        if (p == 1) begin
          n_vec++;
          if (ir !== DW'(16'hA000 + k)) begin n_err++; $display("FAIL plain_ir k=%0d: got %h", k, ir); end
        end
      end
    end
    n_vec++; if (pc !== 16'h0103) begin n_err++; $display("FAIL plain_pc: got %h want 0103", pc); end
  endtask

  task automatic test_load();
    logic [3:0] exp_st [11];
    logic       ack_v  [11];
    exp_st = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd5, 4'd5, 4'd5, 4'd6, 4'd7, 4'd0};
    ack_v  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    dec_load = 1'b1; dec_store = 1'b0; dec_addr = 16'h2000;
    for (int i = 0; i < 11; i++) begin
      bus.mem_ack   = ack_v[i];
      bus.mem_rdata = (i < 2) ? 16'h1111 : ((i == 8) ? 16'hBEEF : 16'hDEAD);
      step();
      n_vec++;
      if (state !== exp_st[i]) begin
        n_err++; $display("FAIL load_state i=%0d: got %0d want %0d", i, state, exp_st[i]);
      end
      if (i == 0) begin
        n_vec++; if (bus.mem_addr !== 16'h0103) begin n_err++; $display("FAIL load_fetch_addr: got %h", bus.mem_addr); end
      end
      if (exp_st[i] == 4'd5) begin
        n_vec++;
        if (bus.mem_addr !== 16'h2000 || bus.mem_req !== 1'b1) begin
          n_err++; $display("FAIL load_io i=%0d: addr %h req %b want 2000/1", i, bus.mem_addr, bus.mem_req);
        end
      end
      if (i == 8) begin
        n_vec++; if (operand !== 16'hBEEF) begin n_err++; $display("FAIL load_operand: got %h want beef", operand); end
      end
    end
    n_vec++; if (ir !== 16'h1111) begin n_err++; $display("FAIL load_ir: got %h want 1111", ir); end
    n_vec++; if (pc !== 16'h0104) begin n_err++; $display("FAIL load_pc: got %h want 0104", pc); end
    dec_load = 1'b0;
  endtask

  task automatic test_store();
    logic [3:0] exp_st [7];
    exp_st = '{4'd1, 4'd2, 4'd3, 4'd7, 4'd8, 4'd9, 4'd0};
    dec_load = 1'b0; dec_store = 1'b1; dec_addr = 16'h3000; alu_result = 16'h1234;
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'h2222;
    for (int i = 0; i < 7; i++) begin
      step();
      n_vec++;
      if (state !== exp_st[i]) begin
        n_err++; $display("FAIL store_state i=%0d: got %0d want %0d", i, state, exp_st[i]);
      end
      n_vec++;
      if (bus.mem_we !== (exp_st[i] == 4'd9)) begin
        n_err++; $display("FAIL store_we i=%0d: got %b", i, bus.mem_we);
      end
      if (i == 0) begin
        n_vec++; if (bus.mem_addr !== 16'h0104) begin n_err++; $display("FAIL store_fetch_addr: got %h", bus.mem_addr); end
      end
      if (exp_st[i] == 4'd9) begin
        n_vec++;
        if (bus.mem_addr !== 16'h3000 || bus.mem_wdata !== 16'h1234 || bus.mem_req !== 1'b1) begin
          n_err++; $display("FAIL store_io: addr %h wdata %h req %b want 3000/1234/1",
                            bus.mem_addr, bus.mem_wdata, bus.mem_req);
        end
      end
    end
    dec_store = 1'b0;
  endtask

  task automatic test_load_store();
    logic [3:0] exp_st [10];
    exp_st = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0};
    dec_load = 1'b1; dec_store = 1'b1; dec_addr = 16'h3100; alu_result = 16'h5678;
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'h3333;
    for (int i = 0; i < 10; i++) begin
      step();
      n_vec++;
      if (state !== exp_st[i]) begin
        n_err++; $display("FAIL ldst_state i=%0d: got %0d want %0d", i, state, exp_st[i]);
      end
      if (exp_st[i] == 4'd9) begin
        n_vec++;
        if (bus.mem_addr !== 16'h3100 || bus.mem_wdata !== 16'h5678 || bus.mem_we !== 1'b1) begin
          n_err++; $display("FAIL ldst_store: addr %h wdata %h we %b", bus.mem_addr, bus.mem_wdata, bus.mem_we);
        end
      end
    end
    n_vec++; if (operand !== 16'h3333) begin n_err++; $display("FAIL ldst_operand: got %h want 3333", operand); end
    n_vec++; if (pc !== 16'h0106) begin n_err++; $display("FAIL ldst_pc: got %h want 0106", pc); end
    dec_load = 1'b0; dec_store = 1'b0;
  endtask

  task automatic test_branch_wrap();
    bus.mem_ack = 1'b1; pc_load = 1'b1; pc_target = 16'hFFFF;
    for (int i = 0; i < 5; i++) step();
    n_vec++; if (pc !== 16'hFFFF) begin n_err++; $display("FAIL branch_to_ffff: got %h", pc); end
    pc_target = 16'h0040;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 0) begin
        n_vec++; if (bus.mem_addr !== 16'hFFFF) begin n_err++; $display("FAIL wrap_fetch_addr: got %h", bus.mem_addr); end
      end
      if (i == 2) begin
        n_vec++; if (pc !== 16'h0000) begin n_err++; $display("FAIL wrap_pc: got %h want 0000", pc); end
      end
    end
    n_vec++; if (pc !== 16'h0040) begin n_err++; $display("FAIL branch_pc: got %h want 0040", pc); end
    pc_load = 1'b0;
    step();
    n_vec++; if (bus.mem_addr !== 16'h0040) begin n_err++; $display("FAIL branch_fetch_addr: got %h", bus.mem_addr); end
    for (int i = 0; i < 4; i++) step();
    n_vec++; if (pc !== 16'h0041) begin n_err++; $display("FAIL branch_next_pc: got %h want 0041", pc); end
  endtask

  task automatic test_run_stop();
    logic [3:0] exp_st [11];
    logic       run_v  [11];
    logic       ack_v  [11];
    exp_st = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd5, 4'd6, 4'd7, 4'd0, 4'd0, 4'd0};
    run_v  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    ack_v  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    dec_load = 1'b1; dec_addr = 16'h2200;
    for (int i = 0; i < 11; i++) begin
      run = run_v[i]; bus.mem_ack = ack_v[i];
      step();
      n_vec++;
      if (state !== exp_st[i]) begin
        n_err++; $display("FAIL runstop_state i=%0d: got %0d want %0d", i, state, exp_st[i]);
      end
    end
    n_vec++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL runstop_req: got 1 want 0"); end
    n_vec++; if (pc !== 16'h0042) begin n_err++; $display("FAIL runstop_pc: got %h want 0042", pc); end
    dec_load = 1'b0;
  endtask

  task automatic test_reset_store();
    logic [3:0] exp_st [6];
    logic       ack_v  [6];
    exp_st = '{4'd1, 4'd2, 4'd3, 4'd7, 4'd8, 4'd9};
    ack_v  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    run = 1'b1; dec_store = 1'b1; dec_addr = 16'h3000;
    for (int i = 0; i < 6; i++) begin
      bus.mem_ack = ack_v[i];
      step();
      n_vec++;
      if (state !== exp_st[i]) begin
        n_err++; $display("FAIL rststore_state i=%0d: got %0d want %0d", i, state, exp_st[i]);
      end
    end
    rst_n = 1'b0; bus.mem_ack = 1'b1;
    step();
    n_vec++;
    if (state !== 4'd0 || bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0) begin
      n_err++; $display("FAIL rststore_abort: state %0d req %b we %b want 0/0/0", state, bus.mem_req, bus.mem_we);
    end
    n_vec++; if (pc !== 16'h0100) begin n_err++; $display("FAIL rststore_pc: got %h want 0100", pc); end
    rst_n = 1'b1; run = 1'b0; dec_store = 1'b0;
    step();
    n_vec++; if (state !== 4'd0) begin n_err++; $display("FAIL rststore_park: got %0d want 0", state); end
  endtask

  task automatic test_timeout();
    run = 1'b1; bus.mem_ack = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      n_vec++;
      if (state !== 4'd1 || bus.mem_req !== 1'b1 || fault !== 1'b0) begin
        n_err++; $display("FAIL timeout_wait i=%0d: state %0d req %b fault %b", i, state, bus.mem_req, fault);
      end
    end
    step();
    n_vec++;
    if (state !== 4'd10 || fault !== 1'b1 || bus.mem_req !== 1'b0) begin
      n_err++; $display("FAIL timeout_fault: state %0d fault %b req %b want 10/1/0", state, fault, bus.mem_req);
    end
    bus.mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if (state !== 4'd10 || fault !== 1'b1 || bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0) begin
        n_err++; $display("FAIL timeout_sticky i=%0d: state %0d fault %b req %b", i, state, fault, bus.mem_req);
      end
    end
    rst_n = 1'b0;
    step();
    n_vec++;
    if (state !== 4'd0 || fault !== 1'b0) begin
      n_err++; $display("FAIL timeout_reset: state %0d fault %b want 0/0", state, fault);
    end
    rst_n = 1'b1; bus.mem_ack = 1'b0;
    step();
    for (int i = 0; i < 4; i++) step();
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'h7777;
    step();
    n_vec++;
    if (state !== 4'd2 || fault !== 1'b0 || ir !== 16'h7777) begin
      n_err++; $display("FAIL timeout_ack_last: state %0d fault %b ir %h want 2/0/7777", state, fault, ir);
    end
    run = 1'b0;
    for (int i = 0; i < 3; i++) step();
  endtask

  task automatic test_no_timeout();
    rst_n2 = 1'b0; run2 = 1'b0; bus2.mem_ack = 1'b0;
    step();
    rst_n2 = 1'b1; run2 = 1'b1;
    step();
    for (int i = 0; i < 100; i++) begin
      step();
      n_vec++;
      if (state2 !== 4'd1 || fault2 !== 1'b0) begin
        n_err++; $display("FAIL notimeout_wait i=%0d: state %0d fault %b want 1/0", i, state2, fault2);
      end
    end
    bus2.mem_ack = 1'b1; bus2.mem_rdata = 16'h4242;
    step();
    n_vec++;
    if (state2 !== 4'd2 || fault2 !== 1'b0 || ir2 !== 16'h4242) begin
      n_err++; $display("FAIL notimeout_ack: state %0d fault %b ir %h want 2/0/4242", state2, fault2, ir2);
    end
  endtask

  initial begin
    test_reset();
    test_plain();
    test_load();
    test_store();
    test_load_store();
    test_branch_wrap();
    test_run_stop();
    test_reset_store();
    test_timeout();
    test_no_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Parametrised multi-cycle control sequencer for the LiteCPU core. It replaces the fixed-state controller with a full fetch/load/calc/store state machine. The machine drives a req/ack memory port, holds PC, IR, effective address and operand registers, and enters a sticky fault state on a bus timeout. It sits between the memory/bus interface and the decoder/ALU datapath.

## Interface
Parameters:
- ADDR_W, 16, address and PC width
- DATA_W, 16, instruction/data width
- MAX_WAIT, 15, max extra IO cycles without ack before fault; 0 disables timeout
- PC_RESET, 0, PC value after reset (ADDR_W bits)

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- run  in  1  permits a new fetch; sampled only in FETCH_BEGIN
- mem_req  out  1  memory request, high in every *_IO state
- mem_we  out  1  write strobe, high only in STORE_IO
- mem_addr  out  ADDR_W  request address, registered
- mem_wdata  out  DATA_W  store data, registered
- mem_rdata  in  DATA_W  read data, valid with mem_ack
- mem_ack  in  1  transfer complete; sampled only in *_IO states
- dec_load, dec_store  in  1 each  decoder flags for current IR; sampled in EXEC_BEGIN
- dec_addr  in  ADDR_W  operand effective address; sampled in EXEC_BEGIN
- alu_result  in  DATA_W  ALU output; sampled in CALC
- pc_load  in  1  branch taken; sampled in CALC
- pc_target  in  ADDR_W  branch target
- ir  out  DATA_W  instruction register
- operand  out  DATA_W  loaded operand
- pc  out  ADDR_W  program counter
- calc_en  out  1  one-cycle pulse, high in CALC
- state  out  4  current state code
- fault  out  1  high in FAULT

## Operation
- State codes: FETCH_BEGIN=0, FETCH_IO=1, FETCH_END=2, EXEC_BEGIN=3, LOAD_BEGIN=4, LOAD_IO=5, LOAD_END=6, CALC=7, STORE_BEGIN=8, STORE_IO=9, FAULT=10. Codes 11–15 go to FAULT.
- FETCH_BEGIN: if run, mem_addr<=pc and go to FETCH_IO. Otherwise stay.
- FETCH_IO: on ack, ir<=mem_rdata and go to FETCH_END.
- FETCH_END: pc<=pc+1, modulo 2^ADDR_W (wraps to 0). Go to EXEC_BEGIN.
- EXEC_BEGIN: latch ea<=dec_addr and the store flag<=dec_store. If dec_load go to LOAD_BEGIN, else CALC.
- LOAD_BEGIN: mem_addr<=ea, go to LOAD_IO. LOAD_IO: on ack, operand<=mem_rdata and go to LOAD_END. LOAD_END: go to CALC.
- CALC: mem_wdata<=alu_result. If pc_load, pc<=pc_target. If the store flag is set go to STORE_BEGIN, else FETCH_BEGIN.
- STORE_BEGIN: mem_addr<=ea, go to STORE_IO. STORE_IO: on ack go to FETCH_BEGIN.
- FAULT: sticky; only rst_n exits. mem_req and mem_we stay 0.
- Timeout: wait_cnt clears on entry to any IO state and increments each IO cycle without ack. With MAX_WAIT>0, if wait_cnt==MAX_WAIT and there is no ack, go to FAULT.

## Timing
- Reset (rst_n low at an edge) gives: state=0, pc=PC_RESET, ir=0, operand=0, mem_addr=0, mem_wdata=0, mem_req=0, mem_we=0, calc_en=0, fault=0, wait_cnt=0.
- Reset mid-transfer drops mem_req in the next cycle. The pending ack is ignored.
- mem_req and mem_we are Moore outputs decoded from the state register. There is no combinational path from mem_ack.
- An ack in the first IO cycle is legal, so each IO state lasts 1 to MAX_WAIT+1 cycles. mem_req falls the cycle after the ack edge.
- An ack outside IO states is ignored.
- Ack and timeout in the same cycle: ack wins.
- Zero-wait latency, FETCH_BEGIN back to FETCH_BEGIN:
  - plain instruction: 5 cycles
  - with load: 8 cycles
  - with store: 7 cycles
  - load+store: 10 cycles
- Deasserting run stops only at FETCH_BEGIN; an instruction already in progress always completes.
- pc_load in CALC overrides the increment already applied in FETCH_END. The PC change is visible from the next cycle.
- calc_en is high exactly one cycle per instruction and never during stalls.

## Test plan
- Reset with PC_RESET=0x0100, then run=1 and ack every IO cycle, three plain instructions → mem_addr 0x0100, 0x0101, 0x0102; calc_en every 5 cycles; pc=0x0103.
- Load with dec_addr=0x2000, mem_rdata=0xBEEF, ack delayed 3 cycles → operand=0xBEEF; mem_addr=0x2000 during LOAD_IO; total 11 cycles.
- Store with alu_result=0x1234, dec_addr=0x3000 → in STORE_IO mem_we=1, mem_addr=0x3000, mem_wdata=0x1234; mem_we=0 in all other states.
- Timeout, MAX_WAIT=4, no ack in FETCH_IO → FAULT after 5 IO cycles; fault=1 and mem_req=0 until rst_n. Repeat with ack on the 5th cycle → no fault. Repeat with MAX_WAIT=0 and ack after 100 cycles → no fault.
- Branch and wrap: pc=0xFFFF fetch → pc becomes 0x0000 after FETCH_END. Then pc_load=1, pc_target=0x0040 in CALC → next fetch address 0x0040.
- Run low during LOAD_IO → the instruction completes and the machine parks in FETCH_BEGIN with mem_req=0. Asserting rst_n low in STORE_IO → mem_req=0 and state=0 on the next cycle.
